// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector: run-time pattern of up to MAX_LEN bits,
// overlapping or non-overlapping matches, registered detect copy and saturating counter.
module seq_det_prog #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               seq_in,
  input  logic               cnt_clr,
  output logic               det_out,
  output logic               det_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   state_out
);

  localparam logic [MAX_LEN-1:0] RST_PAT   = {{(MAX_LEN-4){1'b0}}, 4'b1011};
  localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(4);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   ONE_L     = LEN_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] cand;
  logic               pat_hit;
  logic               fill_full;
  logic               det;

  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0) begin
      len_clamp = ONE_L;
    end else if (cfg_len > MAX_LEN_L) begin
      len_clamp = MAX_LEN_L;
    end
  end

  // Only the low len_q bits of the candidate window take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_q);
  end

  assign cand      = {hist_q[MAX_LEN-2:0], seq_in};
  assign pat_hit   = ((cand ^ pat_q) & len_mask) == '0;
  assign fill_full = (fill_q == (len_q - ONE_L));
  assign det       = in_valid & ~cfg_load & ~rst & fill_full & pat_hit;

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = len_clamp;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      if (det && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand;
        fill_d = fill_full ? fill_q : fill_q + ONE_L;
      end
    end
    // Clear takes effect first so a coincident detect still counts once.
    if (cnt_clr) begin
      cnt_d = det ? CNT_W'(1) : '0;
    end else if (det && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PAT;
      len_q  <= RST_LEN;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      det_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      det_q  <= det;
    end
  end

  assign det_out   = det;
  assign match_cnt = cnt_q;
  assign state_out = fill_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Randomised and directed bench for seq_det_prog, checked every cycle against a
// queue-based model of the accepted bit history.
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               in_valid = 1'b0;
  logic               seq_in = 1'b0;
  logic               cnt_clr = 1'b0;

  logic               det_out, det_q, det_out2, det_q2;
  logic [7:0]         match_cnt;
  logic [1:0]         match_cnt2;
  logic [LEN_W-1:0]   state_out, state_out2;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .seq_in(seq_in), .cnt_clr(cnt_clr), .det_out(det_out), .det_q(det_q),
    .match_cnt(match_cnt), .state_out(state_out)
  );

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .seq_in(seq_in), .cnt_clr(cnt_clr), .det_out(det_out2), .det_q(det_q2),
    .match_cnt(match_cnt2), .state_out(state_out2)
  );

  task automatic check(input string name, input longint act, input longint exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the list of bits accepted since the last clear, plus config.
  bit          mq[$];
  int          m_len = 4;
  bit [7:0]    m_pat = 8'b0000_1011;
  bit          m_ovl = 1'b1;
  bit          m_detq = 1'b0;
  int          m_cnt = 0;
  int          m_cnt2 = 0;

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  function automatic int m_fill();
    return (mq.size() < m_len - 1) ? mq.size() : m_len - 1;
  endfunction

  // The last len bits in time order (oldest first) must equal pattern[len-1] .. pattern[0].
  function automatic bit m_det();
    int base;
    bit b;
    if (rst || cfg_load || !in_valid) return 1'b0;
    if (mq.size() < m_len - 1) return 1'b0;
    base = mq.size() - (m_len - 1);
    for (int k = 0; k < m_len; k++) begin
      b = (k == m_len - 1) ? seq_in : mq[base + k];
      if (b != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin : compare
    bit e;
    e = m_det();
    check("det_out", det_out, e);
    check("det_q", det_q, m_detq);
    check("match_cnt", match_cnt, m_cnt);
    check("match_cnt_w2", match_cnt2, m_cnt2);
    check("state_out", state_out, m_fill());
    if (rst) begin
      mq.delete();
      m_len = 4; m_pat = 8'b0000_1011; m_ovl = 1'b1;
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pattern; m_len = clamp_len(int'(cfg_len)); m_ovl = cfg_overlap;
        mq.delete();
      end else if (in_valid) begin
        if (e && !m_ovl) mq.delete();
        else begin
          mq.push_back(seq_in);
          if (mq.size() > MAX_LEN) void'(mq.pop_front());
        end
      end
      if (cnt_clr) begin
        m_cnt = e ? 1 : 0; m_cnt2 = e ? 1 : 0;
      end else if (e) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    m_detq = e;
  end

  logic [15:0] dv;

  // Drive one cycle of inputs at posedge+1, record det_out, return at next posedge+1.
  task automatic cyc(input bit r, input bit ld, input bit v, input bit s, input bit clr);
    rst = r; cfg_load = ld; in_valid = v; seq_in = s; cnt_clr = clr;
    #1;
    dv = {dv[14:0], det_out};
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int n, input logic [15:0] bits);
    for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b0, 1'b1, bits[i], 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit o, input bit clr);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, clr);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_cnt", match_cnt, 0);
    check("rst_fill", state_out, 0);

    // Legacy 1011 overlapping
    rst = 1'b0;
    dv = '0; send_bits(7, 16'b1011011);
    check("tp1_det", dv[6:0], 7'b0001001);
    check("tp1_detq", det_q, 1);
    check("tp1_cnt", match_cnt, 2);

    // 110 non-overlapping, counter cleared alongside the load
    load(8'b0000_0110, 3, 1'b0, 1'b1);
    dv = '0; send_bits(9, 16'b110110110);
    check("tp2_det", dv[8:0], 9'b001001001);
    check("tp2_fill", state_out, 0);
    check("tp2_cnt", match_cnt, 3);

    load(8'b0000_0101, 3, 1'b1, 1'b0);
    dv = '0; send_bits(5, 16'b10101);
    check("tp3_ovl", dv[4:0], 5'b00101);
    load(8'b0000_0101, 3, 1'b0, 1'b0);
    dv = '0; send_bits(5, 16'b10101);
    check("tp3_novl", dv[4:0], 5'b00100);

    // Idle cycles keep a partial match
    load(8'b0000_1011, 4, 1'b1, 1'b0);
    dv = '0; send_bits(2, 16'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, i[0], 1'b0);
      check("tp4_idle_fill", state_out, 2);
    end
    dv = '0; send_bits(2, 16'b11);
    check("tp4_det", dv[1:0], 2'b01);

    // len 0 -> 1; saturation on the 2-bit counter; clear with coincident detect
    load(8'h01, 0, 1'b1, 1'b1);
    dv = '0; send_bits(7, 16'b1101111);
    check("tp5_det", dv[6:0], 7'b1101111);
    check("tp5_cnt2_sat", match_cnt2, 3);
    check("tp5_cnt", match_cnt, 6);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("tp5_clr_det", match_cnt, 1);
    check("tp5_clr_det2", match_cnt2, 1);

    // cfg_len above MAX_LEN clamps to MAX_LEN
    load(8'hA5, 15, 1'b1, 1'b0);
    dv = '0; send_bits(8, 16'hA5);
    check("tp6_det", dv[7:0], 8'b0000_0001);

    // Reset mid-pattern restores 1011 config
    load(8'h0D, 4, 1'b0, 1'b0);
    dv = '0; send_bits(3, 16'b101);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bits(1, 16'b1);
    check("tp7_nodet", dv[1:0], 2'b00);
    dv = '0; send_bits(3, 16'b011);
    check("tp7_1011", dv[2:0], 3'b001);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      cfg_pattern = 8'($urandom);
      cfg_len     = LEN_W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 5));
      cfg_overlap = 1'($urandom);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 99) == 0));
    end

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
